// File: rtl/demux_reg_bank_if.sv
// Write-stream bundle into demux_reg_bank: valid/ready beat with target select, burst length and data.
interface demux_reg_bank_if #(
  parameter int WIDTH     = 32,
  parameter int SEL_WIDTH = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [SEL_WIDTH-1:0] in_sel;
  logic [SEL_WIDTH:0]   in_len;
  logic [WIDTH-1:0]     in_data;

  modport master (output in_valid, in_sel, in_len, in_data, input in_ready);
  modport slave  (input in_valid, in_sel, in_len, in_data, output in_ready);
endinterface

// File: rtl/demux_reg_bank.sv
// Registered 1-to-N write demux: single, broadcast and auto-incrementing burst writes into holding registers.
// Accepted beat lands in q and pulses upd on the following cycle; hold (or reset) drops in_ready, stalling the source.
module demux_reg_bank #(
  parameter int WIDTH     = 32,
  parameter int SEL_WIDTH = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 hold,
  demux_reg_bank_if.slave                      wr,
  output logic [WIDTH*(2**SEL_WIDTH)-1:0]      q,
  output logic [(2**SEL_WIDTH)-1:0]            upd,
  output logic                                 busy
);
  localparam int NUM_OUT = 2**SEL_WIDTH;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;
  localparam logic [SEL_WIDTH:0] LEN_MAX = (SEL_WIDTH+1)'(NUM_OUT);
  localparam logic [SEL_WIDTH:0] LEN_ONE = (SEL_WIDTH+1)'(1);
  localparam logic [SEL_WIDTH:0] LEN_ZERO = '0;

  logic [0:0]           state, state_nxt;
  logic [SEL_WIDTH-1:0] idx, idx_nxt;
  logic [SEL_WIDTH:0]   remaining, rem_nxt;
  logic [SEL_WIDTH:0]   eff_len;
  logic [NUM_OUT-1:0]   wr_mask;
  logic                 accept;

  assign wr.in_ready = ~hold & ~rst;
  assign accept      = wr.in_valid & wr.in_ready;
  assign busy        = (state == S_BURST);

  // Lengths beyond NUM_OUT clamp so a burst never revisits a register.
  assign eff_len = (wr.in_len > LEN_MAX) ? LEN_MAX : wr.in_len;

  always_comb begin
    wr_mask   = '0;
    state_nxt = state;
    idx_nxt   = idx;
    rem_nxt   = remaining;
    if (accept) begin
      if (state == S_IDLE) begin
        if (eff_len == LEN_ZERO) begin
          wr_mask = '1;
        end else begin
          wr_mask[wr.in_sel] = 1'b1;
          if (eff_len > LEN_ONE) begin
            state_nxt = S_BURST;
            idx_nxt   = wr.in_sel + 1'b1;
            rem_nxt   = eff_len - 1'b1;
          end
        end
      end else begin
        // Burst continuation: sel/len on the bus are ignored.
        wr_mask[idx] = 1'b1;
        idx_nxt      = idx + 1'b1;
        rem_nxt      = remaining - 1'b1;
        if (remaining == LEN_ONE) state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= '0;
      upd       <= '0;
      state     <= S_IDLE;
      idx       <= '0;
      remaining <= '0;
    end else begin
      upd       <= wr_mask;
      state     <= state_nxt;
      idx       <= idx_nxt;
      remaining <= rem_nxt;
      for (int i = 0; i < NUM_OUT; i++) begin
        if (wr_mask[i]) q[i*WIDTH +: WIDTH] <= wr.in_data;
      end
    end
  end
endmodule

// File: doc/demux_reg_bank.md
Name: demux_reg_bank

Overview:
- Registered 1-to-N demultiplexer. It routes one WIDTH-bit write stream into one of NUM_OUT holding registers.
- Supports single-beat, broadcast and auto-incrementing burst writes.
- Sits on the CPU store/write-back side. It distributes data to peripheral and control registers, and its outputs feed the selector muxes on the read side.

Parameters:
- WIDTH, 32, data width of each holding register.
- SEL_WIDTH, 3, select width; NUM_OUT = 2**SEL_WIDTH (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- hold  in  1  downstream stall; blocks acceptance.
- in_valid  in  1  write beat present.
- in_ready  out  1  beat accepted when in_valid & in_ready at clk edge.
- in_sel  in  SEL_WIDTH  target register index (sampled on first beat only).
- in_len  in  SEL_WIDTH+1  burst length in beats (sampled on first beat only); 0 = broadcast.
- in_data  in  WIDTH  write data.
- q  out  WIDTH*NUM_OUT  flattened holding registers; q[i] = bits [i*WIDTH +: WIDTH].
- upd  out  NUM_OUT  one-cycle update strobe per register.
- busy  out  1  high while in BURST state.

Behaviour:
- Reset (rst high at edge):
  - q all 0, upd 0, busy 0, state IDLE, idx 0, remaining 0.
  - in_ready = 0 while rst is high.
  - Reset mid-burst abandons the burst; no partial state survives.
- in_ready = ~hold & ~rst (combinational). Beats offered while hold=1 are not accepted; the source must hold in_valid and its data stable.
- Write latency: an accepted beat updates its target register on the same edge. q shows the new value from the next cycle. The upd bit is registered and asserted in that same cycle, for exactly one cycle per accepted write.
- FSM states: IDLE, BURST.
- IDLE, on an accepted beat:
  - in_len = 0: write in_data to all NUM_OUT registers; upd = all ones; stay IDLE.
  - in_len = 1: write q[in_sel]; upd one-hot at in_sel; stay IDLE.
  - in_len > NUM_OUT: clamp to NUM_OUT.
  - 2 ≤ in_len ≤ NUM_OUT: write q[in_sel]; idx = in_sel+1 mod NUM_OUT; remaining = len-1; go BURST; busy = 1 from the next cycle.
- BURST, on an accepted beat:
  - in_sel and in_len are ignored.
  - Write q[idx]; upd one-hot at idx; idx wraps from NUM_OUT-1 to 0; remaining decrements.
  - When remaining reaches 0 (last beat accepted), go IDLE; busy = 0 from the next cycle.
- BURST, with no accepted beat (in_valid=0 or hold=1): state, idx and remaining hold; upd = 0.
- Registers not written in a cycle keep their value. upd = 0 in every cycle following a non-accepting edge.
- A burst never writes the same register twice, because length is capped at NUM_OUT.
- No combinational path from in_data to q. q and upd depend only on flops.

Test Plan:
- Reset, then in_valid=1, in_sel=5, in_len=1, in_data=0xDEADBEEF for one cycle → next cycle q[5]=0xDEADBEEF, upd=8'b0010_0000 for 1 cycle, all other q = 0, busy stays 0.
- in_len=0, in_data=0x12345678 → all eight q = 0x12345678, upd=0xFF for 1 cycle.
- Burst in_sel=6, in_len=4, data 0xA0..0xA3 on consecutive cycles → q[6]=0xA0, q[7]=0xA1, q[0]=0xA2 (wrap), q[1]=0xA3. Sequence upd=0x40,0x80,0x01,0x02; busy high for the 3 cycles after the first beat; IDLE after.
- Burst in_sel=2, in_len=3 with hold=1 on the second beat for 2 cycles and in_valid gap of 1 cycle → in_ready=0 during hold, no writes and upd=0 in those cycles. Final q[2..4] = the three beat values; exactly 3 upd pulses.
- in_len=12 (> NUM_OUT) from in_sel=0 → exactly 8 beats accepted; q[0..7] written in order; IDLE after the 8th beat.
- Reset asserted after beat 2 of a 5-beat burst → next cycle q all 0, busy 0, upd 0. A following single write (in_sel=3, in_len=1) is decoded as a fresh IDLE command.
